insn_fetch: RTL and testbench

- Instruction fetch stage of the stack CPU. Sits directly upstream of the instruction decoder.
- Fetches 16-bit instruction words from program memory at the fetch pointer and buffers them in a small prefetch queue.
- Presents the head instruction and its address to decode/execute through a valid/ready handshake.
- Honours ip redirects (load_ip from execute) by flushing the queue and refetching.

---
 rtl/insn_fetch.sv | 141 ++++++++++++++
 tb/tb_insn_fetch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch.sv
// insn_fetch -- instruction fetch stage of the stack CPU.
//
// Fetches 16-bit instruction words from program memory at the fetch pointer,
// buffers them in a DEPTH-entry prefetch queue and presents the head word and
// its byte address to the decoder through a valid/ready handshake. A redirect
// (load_ip) flushes the queue and restarts fetching at new_ip; a fetch already
// in flight at that moment completes at its old address and its data is dropped.
//
// Parameters:
//   DEPTH     prefetch queue entries (power of 2, >= 2)
//   RESET_IP  fetch address after reset (bit 0 ignored)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_req / mem_addr    fetch request and its (even) byte address
//   mem_ack / mem_rdata   fetch completion and instruction word
//   insn / insn_ip        head instruction and its byte address
//   insn_valid            head is valid
//   insn_ready            consumer accepts the head this cycle
//   load_ip / new_ip      redirect request and target
//
// Optional feature macro: FETCH_BYPASS_EN -- when the queue is empty an
// acknowledged word is forwarded combinationally to insn in the ack cycle.

module insn_fetch #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [15:0] RESET_IP = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [15:0] insn,
   output logic [15:0] insn_ip,
   output logic        insn_valid,
   input  logic        insn_ready,
   input  logic        load_ip,
   input  logic [15:0] new_ip
);

   localparam int unsigned CW  = $clog2(DEPTH);
   localparam int unsigned CW1 = CW + 1;
   localparam logic [CW:0]   DEPTH_C = CW1'(DEPTH);
   localparam logic [CW:0]   CNT_ONE = CW1'(1);
   localparam logic [CW-1:0] PTR_ONE = CW'(1);
   localparam logic [15:0]   IP_RST  = RESET_IP & 16'hfffe;

   logic [15:0] q_data [DEPTH];
   logic [15:0] q_addr [DEPTH];
   logic [CW-1:0] rd_ptr, wr_ptr;
   logic [CW:0]   count;
   logic [15:0]   fp;
   logic [15:0]   req_addr;
   logic          pending;
   logic          discard;

   logic          ack_acc, take, bypass, byp_used, push, pop, pend_hold;
   logic [CW:0]   count_nx;
   logic [15:0]   fp_nx;

   always_comb begin
      ack_acc   = pending & mem_ack;
      // a word belongs to the instruction stream only if no redirect claims it
      take      = ack_acc & ~discard & ~load_ip;
`ifdef FETCH_BYPASS_EN
      bypass    = take & (count == '0);
`else
      bypass    = 1'b0;
`endif
      byp_used  = bypass & insn_ready;
      push      = take & ~byp_used;
      pop       = (count != '0) & insn_ready;
      pend_hold = pending & ~mem_ack;

      if (load_ip) begin
         count_nx = '0;
         fp_nx    = new_ip & 16'hfffe;
      end else begin
         count_nx = count;
         if (push && !pop)
            count_nx = count + CNT_ONE;
         else if (pop && !push)
            count_nx = count - CNT_ONE;
         fp_nx = take ? fp + 16'd2 : fp;
      end
   end

   always_comb begin
      mem_req    = pending;
      mem_addr   = req_addr;
      insn_valid = (count != '0) | bypass;
      insn       = '0;
      insn_ip    = '0;
      if (bypass) begin
         insn    = mem_rdata;
         insn_ip = req_addr;
      end else if (count != '0) begin
         insn    = q_data[rd_ptr];
         insn_ip = q_addr[rd_ptr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fp       <= IP_RST;
         req_addr <= IP_RST;
         pending  <= 1'b0;
         discard  <= 1'b0;
      end else begin
         count <= count_nx;
         fp    <= fp_nx;
         if (load_ip) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         end
         // count_nx + pending_nx never exceeds DEPTH, so a later push has room
         pending <= pend_hold | (count_nx < DEPTH_C);
         // address stays frozen while a request is outstanding
         if (!pend_hold) req_addr <= fp_nx;
         // a redirect over an in-flight request poisons exactly that request
         discard <= pend_hold & (load_ip | discard);
      end
   end

   // storage needs no reset: outputs are gated by count
   always_ff @(posedge clk) begin
      if (push) begin
         q_data[wr_ptr] <= mem_rdata;
         q_addr[wr_ptr] <= req_addr;
      end
   end

endmodule

// File: tb/tb_insn_fetch.sv
// Self-checking bench for insn_fetch (DEPTH = 2, RESET_IP = 16'h0100).
// A memory model answers requests after a programmable latency with
// rdata = addr ^ 16'hA5A5. A reference model predicts the fetch stream; every
// accepted, non-dropped word is pushed to a scoreboard and popped when the
// consumer takes the head.

module tb_insn_fetch;

   localparam int          DEPTH    = 2;
   localparam logic [15:0] RESET_IP = 16'h0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] insn;
   logic [15:0] insn_ip;
   logic        insn_valid;
   logic        insn_ready;
   logic        load_ip;
   logic [15:0] new_ip;

   insn_fetch #(.DEPTH(DEPTH), .RESET_IP(RESET_IP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .insn       (insn),
      .insn_ip    (insn_ip),
      .insn_valid (insn_valid),
      .insn_ready (insn_ready),
      .load_ip    (load_ip),
      .new_ip     (new_ip)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   logic [31:0] sb[$];
   logic [15:0] m_fp, m_addr;
   logic        m_req, m_disc;
   int          wcnt, lat, acks;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_fp   = RESET_IP & 16'hfffe;
      m_addr = RESET_IP & 16'hfffe;
      m_req  = 1'b0;
      m_disc = 1'b0;
      wcnt   = 0;
   endtask

   task automatic cycle(input bit rdy, input bit ld, input logic [15:0] nip);
      bit acc, hold, was_empty, byp_used;
      logic [31:0] e;
      @(negedge clk);
      mem_ack = 1'b0; load_ip = 1'b0; insn_ready = 1'b0; new_ip = '0;
      #1;
      check("insn_valid", {15'd0, insn_valid}, {15'd0, (sb.size() != 0)});
      check("mem_req", {15'd0, mem_req}, {15'd0, m_req});
      if (m_req) check("mem_addr", mem_addr, m_addr);
      was_empty = (sb.size() == 0);
      if (rdy && !was_empty) begin
         e = sb.pop_front();
         check("insn_ip", insn_ip, e[31:16]);
         check("insn", insn, e[15:0]);
      end

      insn_ready = rdy;
      load_ip    = ld;
      new_ip     = nip;
      mem_ack    = mem_req && (wcnt >= lat);
      mem_rdata  = mem_ack ? (mem_addr ^ 16'hA5A5) : 16'($urandom);
      acc        = m_req && mem_ack;
      byp_used   = 1'b0;
`ifdef FETCH_BYPASS_EN
      if (acc && !m_disc && !ld && was_empty) begin
         #1;
         check("byp_valid", {15'd0, insn_valid}, 16'd1);
         check("byp_ip", insn_ip, m_fp);
         check("byp_insn", insn, m_fp ^ 16'hA5A5);
         byp_used = rdy;
      end
`endif

      if (ld) begin
         sb.delete();
         m_disc = m_req && !mem_ack;
         m_fp   = nip & 16'hfffe;
      end else if (acc) begin
         acks++;
         if (m_disc) m_disc = 1'b0;
         else begin
            if (!byp_used) sb.push_back({m_fp, m_fp ^ 16'hA5A5});
            m_fp = m_fp + 16'd2;
         end
      end
      hold = m_req && !mem_ack;
      if (!hold) m_addr = m_fp;
      m_req = hold || (sb.size() < DEPTH);

      if (mem_ack) wcnt = 0;
      else if (mem_req) wcnt++;
      @(posedge clk);
   endtask

   // reset held across two falling edges, a stray ack is presented during
   // reset and in the release cycle; both must be ignored
   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      mem_ack = 1'b1; mem_rdata = 16'hdead;
      repeat (2) @(negedge clk);
      check("rst_mem_req", {15'd0, mem_req}, 16'd0);
      check("rst_mem_addr", mem_addr, RESET_IP);
      check("rst_valid", {15'd0, insn_valid}, 16'd0);
      check("rst_insn", insn, 16'd0);
      check("rst_insn_ip", insn_ip, 16'd0);
      rst_n = 1'b1;
      @(posedge clk);
      m_req  = 1'b1;
      m_addr = m_fp;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      mem_ack = 0; mem_rdata = '0; insn_ready = 0; load_ip = 0; new_ip = '0;
      lat = 0; acks = 0;
      do_reset();

      // consumer stalled: exactly DEPTH acks land, then requests stop
      acks = 0;
      repeat (6) cycle(0, 0, '0);
      check("acks_when_full", 16'(acks), 16'(DEPTH));

      // one pop frees a slot; the next request goes to 0104 with slow memory
      lat = 3;
      cycle(1, 0, '0);
      for (int k = 0; k < 8; k++) begin
         if (m_req && wcnt == 1) break;
         cycle(0, 0, '0);
      end
      // redirect while 0104 is in flight
      cycle(0, 1, 16'h0421);
      repeat (14) cycle(1, 0, '0);

      // zero-wait streaming, then redirect colliding with pop and ack
      lat = 0;
      repeat (4) cycle(1, 0, '0);
      cycle(1, 1, 16'h2000);
      repeat (3) cycle(1, 0, '0);

      // address wrap
      cycle(1, 1, 16'hfffe);
      repeat (6) cycle(1, 0, '0);

      // back-to-back redirects over a slow request
      lat = 2;
      cycle(0, 0, '0);
      cycle(0, 1, 16'h1234);
      cycle(0, 1, 16'h5678);
      repeat (8) cycle(1, 0, '0);

      // random mix
      for (int i = 0; i < 80; i++) begin
         if (!m_req) lat = $urandom_range(0, 2);
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0), 16'($urandom));
      end

      // asynchronous reset in the middle of a pending request, queue non-empty
      lat = 3;
      repeat (6) cycle(0, 0, '0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_mem_req", {15'd0, mem_req}, 16'd0);
      check("arst_mem_addr", mem_addr, RESET_IP);
      check("arst_valid", {15'd0, insn_valid}, 16'd0);
      check("arst_insn", insn, 16'd0);
      check("arst_insn_ip", insn_ip, 16'd0);
      do_reset();
      lat = 0;
      repeat (8) cycle(1, 0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
